// File: rtl/video_axis_pkg.sv
// ---------------------------------------------------------------------------
// video_axis_pkg
//   Shared definitions for the video AXI4-Stream blocks in front of the
//   rgb2YCbCr converter.
//   Contents:
//     arb_state_e      arbiter FSM states (IDLE, PASS)
//     DEF_DATA_W       default pixel width (R[23:16] G[15:8] B[7:0])
//     DEF_H_ACTIVE     default beats per line
//     DEF_V_ACTIVE     default lines per frame
//     ERR_*            bit positions inside err_flags
// ---------------------------------------------------------------------------
package video_axis_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_e;

    localparam int DEF_DATA_W   = 24;
    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_V_ACTIVE = 1080;

    localparam int ERR_SHORT_LINE = 0;
    localparam int ERR_LONG_LINE  = 1;
    localparam int ERR_EARLY_SOF  = 2;

endpackage

// File: rtl/axis_reg_slice.sv
// ---------------------------------------------------------------------------
// axis_reg_slice
//   1-deep registered AXI4-Stream slice carrying tdata/tuser/tlast.
//   Upstream ready is !valid || m_tready, so a full slice drains and refills
//   in the same cycle and continuous valid/ready streams without bubbles.
//   Ports:
//     clk_in, reset_n          clock, synchronous active-low reset
//     s_tdata/tvalid/tuser/tlast, s_tready   upstream side
//     m_tdata/tvalid/tuser/tlast, m_tready   downstream side
// ---------------------------------------------------------------------------
module axis_reg_slice #(
    parameter int DATA_W = 24
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tuser,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tuser,
    output logic              m_tlast,
    input  logic              m_tready
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              user_q;
    logic              last_q;

    assign s_tready = !valid_q || m_tready;

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (s_tready) begin
            valid_q <= s_tvalid;
            // Payload only moves with a real beat so an idle slot keeps the
            // last forwarded values instead of sampling an undriven bus.
            if (s_tvalid) begin
                data_q <= s_tdata;
                user_q <= s_tuser;
                last_q <= s_tlast;
            end
        end
    end

    assign m_tvalid = valid_q;
    assign m_tdata  = data_q;
    assign m_tuser  = user_q;
    assign m_tlast  = last_q;

endmodule

// File: rtl/axis_frame_arbiter.sv
// ---------------------------------------------------------------------------
// axis_frame_arbiter
//   Frame-granular 2:1 AXI4-Stream arbiter sharing the colour-space converter
//   between two RGB sources. A grant is taken only on a start-of-frame beat
//   and held until the V_ACTIVE-th tlast of that frame is accepted.
//   Output goes through axis_reg_slice (latency 1).
//   Optional macro: AXIS_FRAME_ARB_LINE_CHECK_EN builds the sticky line /
//   early-SOF checks; without it err_flags is constant 3'b000.
//   Ports:
//     clk_in, reset_n       clock, synchronous active-low reset
//     src_en[1:0]           per-source enable, used only while IDLE
//     s0_* / s1_*           source AXIS inputs (tdata/tvalid/tuser/tlast/tready)
//     m_*                   AXIS output to the converter
//     busy                  a frame grant is held
//     cur_src               granted / last-granted source
//     frame_done            pulse in the cycle the last beat is accepted
//     err_flags[2:0]        sticky {early SOF, long line, short line}
// ---------------------------------------------------------------------------
module axis_frame_arbiter
    import video_axis_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic [1:0]        src_en,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s0_tvalid,
    input  logic              s0_tuser,
    input  logic              s0_tlast,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic              s1_tvalid,
    input  logic              s1_tuser,
    input  logic              s1_tlast,
    output logic              s1_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tuser,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic              busy,
    output logic              cur_src,
    output logic              frame_done,
    output logic [2:0]        err_flags
);

    localparam int X_W = $clog2(H_ACTIVE + 1);
    localparam int Y_W = $clog2(V_ACTIVE + 1);
    localparam logic [X_W-1:0] X_MAX  = X_W'(H_ACTIVE);
    localparam logic [X_W:0]   X_LINE = (X_W + 1)'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_END  = Y_W'(V_ACTIVE);

    arb_state_e     state_q, state_d;
    logic           cur_src_q, cur_src_d;
    logic           rr_q, rr_d;
    logic [X_W-1:0] x_cnt_q, x_cnt_d, x_eff;
    logic [Y_W-1:0] y_cnt_q, y_cnt_d, y_eff, y_new;

    logic [DATA_W-1:0] src_tdata [2];
    logic [1:0]        src_tvalid, src_tuser, src_tlast, src_tready, cand;
    logic              slice_ready, sel_tvalid, sel_tuser, sel_tlast, accept;
    logic              restart;

    assign src_tdata[0] = s0_tdata;
    assign src_tdata[1] = s1_tdata;
    assign src_tvalid   = {s1_tvalid, s0_tvalid};
    assign src_tuser    = {s1_tuser, s0_tuser};
    assign src_tlast    = {s1_tlast, s0_tlast};

    // Per-source handshake: in IDLE an enabled source either has its stray
    // mid-frame beats flushed or, on SOF, becomes a candidate whose SOF beat
    // stays put until the grant. In PASS only the owner sees the slice ready.
    // Everything is held off while reset is asserted so no beat is consumed.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign cand[gi] = src_en[gi] && src_tvalid[gi] && src_tuser[gi];
            assign src_tready[gi] = reset_n &&
                ((state_q == IDLE) ? (src_en[gi] && src_tvalid[gi] && !src_tuser[gi])
                                   : ((cur_src_q == 1'(gi)) && slice_ready));
        end
    endgenerate

    assign s0_tready = src_tready[0];
    assign s1_tready = src_tready[1];

    assign sel_tvalid = (state_q == PASS) && src_tvalid[cur_src_q];
    assign sel_tuser  = src_tuser[cur_src_q];
    assign sel_tlast  = src_tlast[cur_src_q];
    assign accept     = reset_n && sel_tvalid && slice_ready;

`ifdef AXIS_FRAME_ARB_LINE_CHECK_EN
    logic [2:0] err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        cur_src_d  = cur_src_q;
        rr_d       = rr_q;
        x_cnt_d    = x_cnt_q;
        y_cnt_d    = y_cnt_q;
        x_eff      = x_cnt_q;
        y_eff      = y_cnt_q;
        y_new      = '0;
        restart    = 1'b0;
        frame_done = 1'b0;
`ifdef AXIS_FRAME_ARB_LINE_CHECK_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (cand != 2'b00) begin
                    state_d   = PASS;
                    // Both contending: the source that did not finish last wins.
                    cur_src_d = (cand == 2'b11) ? !rr_q : cand[1];
                    x_cnt_d   = '0;
                    y_cnt_d   = '0;
                end
            end
            PASS: begin
                if (accept) begin
                    // A SOF inside a frame restarts the position count at this
                    // beat; the grant is kept.
                    restart = sel_tuser && ((x_cnt_q != '0) || (y_cnt_q != '0));
                    if (restart) begin
                        x_eff = '0;
                        y_eff = '0;
`ifdef AXIS_FRAME_ARB_LINE_CHECK_EN
                        err_d[ERR_EARLY_SOF] = 1'b1;
`endif
                    end
                    if (sel_tlast) begin
`ifdef AXIS_FRAME_ARB_LINE_CHECK_EN
                        if (({1'b0, x_eff} + (X_W + 1)'(1)) < X_LINE)
                            err_d[ERR_SHORT_LINE] = 1'b1;
`endif
                        y_new   = y_eff + Y_W'(1);
                        x_cnt_d = '0;
                        if (y_new == Y_END) begin
                            frame_done = 1'b1;
                            rr_d       = cur_src_q;
                            y_cnt_d    = '0;
                            state_d    = IDLE;
                        end else begin
                            y_cnt_d = y_new;
                        end
                    end else begin
`ifdef AXIS_FRAME_ARB_LINE_CHECK_EN
                        if (x_eff == X_MAX)
                            err_d[ERR_LONG_LINE] = 1'b1;
`endif
                        // Saturate on an over-long line rather than wrapping.
                        x_cnt_d = (x_eff == X_MAX) ? x_eff : x_eff + X_W'(1);
                        y_cnt_d = y_eff;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cur_src_q <= 1'b0;
            rr_q      <= 1'b0;
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
`ifdef AXIS_FRAME_ARB_LINE_CHECK_EN
            err_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cur_src_q <= cur_src_d;
            rr_q      <= rr_d;
            x_cnt_q   <= x_cnt_d;
            y_cnt_q   <= y_cnt_d;
`ifdef AXIS_FRAME_ARB_LINE_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

`ifdef AXIS_FRAME_ARB_LINE_CHECK_EN
    assign err_flags = err_q;
`else
    assign err_flags = 3'b000;
`endif

    assign busy    = (state_q == PASS);
    assign cur_src = cur_src_q;

    axis_reg_slice #(
        .DATA_W (DATA_W)
    ) u_slice (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .s_tdata  (src_tdata[cur_src_q]),
        .s_tvalid (sel_tvalid),
        .s_tuser  (sel_tuser),
        .s_tlast  (sel_tlast),
        .s_tready (slice_ready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tuser  (m_tuser),
        .m_tlast  (m_tlast),
        .m_tready (m_tready)
    );

endmodule
